riscv_test_monitor: RTL
=======================

Name: riscv_test_monitor

Overview:
- Synthesizable end-of-test monitor that sits directly downstream of the CPU core.
- Consumes decode-stage PC/instruction, stall flag and architectural x3 (gp).
- Decides when a riscv-tests program has finished, and whether it passed, failed (with test number) or timed out.
- Replaces ad-hoc $finish logic in benches; usable in FPGA builds to drive status LEDs.

Parameters:
- TIMEOUT, 1000: RUN-state cycles before forced timeout.
- DRAIN_CYCLES, 4: cycles waited after halt detection so in-flight writebacks to gp commit.
- HANG_CYCLES, 8: consecutive non-stalled cycles with unchanged PC that count as a self-loop halt.
- ECALL_INST, 32'h00000073: halt instruction encoding.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- pc  input  32  decode-stage PC.
- inst  input  32  decode-stage instruction.
- stall  input  1  pipeline stall flag; decode contents are not advancing when 1.
- gp  input  32  current value of register x3.
- done  output  1  test finished (sticky until reset).
- pass  output  1  test passed (valid when done).
- fail  output  1  test failed or timed out (valid when done).
- timeout  output  1  finish caused by TIMEOUT.
- test_num  output  31  failing test number, gp[31:1]; 0 on pass or timeout.
- cycles  output  32  RUN+DRAIN cycle count, frozen at done.

Behaviour:
- Interface: one clock `clk`; reset `reset` is asynchronous and active-high.
- Reset values: all outputs 0; state RUN; all counters 0.

States: RUN, DRAIN, DONE.

RUN:
- cycles increments every clock.
- Ecall halt: if stall=0 and inst==ECALL_INST, go to DRAIN and load drain counter with DRAIN_CYCLES-1.
- Hang tracking: hang counter increments when stall=0 and pc equals the registered pc of the previous cycle.
  - Clears when pc differs.
  - Holds when stall=1.
- Hang halt: when the hang counter reaches HANG_CYCLES-1 on a qualifying cycle, go to DRAIN.
- Timeout: when cycles==TIMEOUT-1 and no halt condition in the same cycle, go to DONE with timeout=1, fail=1, pass=0, test_num=0.
- Halt beats timeout on the same cycle.

DRAIN:
- cycles keeps incrementing; timeout is not checked.
- Drain counter decrements each cycle; at 0, sample gp and go to DONE:
  - gp==1 → pass=1.
  - gp[0]==1 and gp!=1 → fail=1, test_num=gp[31:1].
  - gp[0]==0 → fail=1, test_num=0 (malformed result).
- DRAIN_CYCLES=1 samples gp on the first DRAIN cycle.

DONE:
- All outputs registered and held; cycles frozen.
- Further ecalls, hangs and pc changes are ignored.
- done rises in the same cycle as pass/fail/timeout; never partially valid.
- Exactly one of pass/fail is 1 when done=1; both are 0 when done=0.

Widths and counters:
- cycles saturates at 32'hFFFFFFFF (unreachable with legal TIMEOUT).
- Hang and drain counters use $clog2 widths of their parameters (minimum 1 bit).

Reset mid-operation: asynchronous return to RUN with all counters and outputs cleared, regardless of state.

Decomposition:
- Shared `define.vh`:
  - ECALL encoding constant.
  - GP register index (3).
  - Monitor state encodings (MON_RUN, MON_DRAIN, MON_DONE).
  - Result-code constants used by benches.
- One natural sub-module, `pc_hang_detector`:
  - Holds the registered previous PC and the hang counter.
  - Parameter HANG_CYCLES.
  - Inputs clk, reset, pc, stall, enable.
  - Output hang pulse.
- Top-level holds the FSM, the drain counter and the cycle counter.

Test Plan:
- Pass via ecall: pc advances by 4 each cycle, ecall at cycle 20, gp=1 → done=1, pass=1, test_num=0, cycles=24 (DRAIN_CYCLES=4).
- Fail with late gp write: ecall at cycle 30, gp=1 until cycle 32, then 0x0000000B → fail=1, test_num=5; the late write must be captured by the drain.
- Self-loop hang: pc held at 0x00000100 with stall=0, gp=1 → done after 8 unchanged cycles + 4 drain cycles, pass=1.
  - Inserting stall=1 cycles mid-loop delays done by the same count.
- Timeout: pc toggles continuously, never ecall → done at cycle 1000, timeout=1, fail=1, pass=0.
  - An ecall presented exactly at cycle 999 instead yields DRAIN and a gp-based result.
- Stalled ecall: inst=ECALL with stall=1 for 5 cycles → no transition; transition on the first cycle stall drops.
- Reset mid-DRAIN and in DONE: assert reset asynchronously (between clock edges) → all outputs 0 immediately, cycles=0, and a fresh test runs correctly afterwards.

Source files
------------

// File: rtl/riscv_test_monitor_pkg.sv
// Shared constants and encodings for the riscv-tests end-of-test monitor.
// Benches import this package for the halt encoding and result codes.
package riscv_test_monitor_pkg;

    localparam logic [31:0] ECALL_INST_DEFAULT = 32'h0000_0073;
    localparam logic [4:0]  GP_REG_IDX         = 5'd3;

    typedef enum logic [1:0] {
        MON_RUN   = 2'd0,
        MON_DRAIN = 2'd1,
        MON_DONE  = 2'd2
    } mon_state_e;

    typedef enum logic [1:0] {
        RES_NONE    = 2'd0,
        RES_PASS    = 2'd1,
        RES_FAIL    = 2'd2,
        RES_TIMEOUT = 2'd3
    } mon_result_e;

    function automatic mon_result_e result_code(input logic done, input logic pass,
                                                input logic timeout);
        if (!done)
            return RES_NONE;
        else if (pass)
            return RES_PASS;
        else if (timeout)
            return RES_TIMEOUT;
        else
            return RES_FAIL;
    endfunction

endpackage

// File: rtl/riscv_test_monitor_pc_hang_detector.sv
// Detects a core spinning on one PC (the usual riscv-tests self-loop halt).
// Pulses hang on the HANG_CYCLES-th consecutive non-stalled repeat of the PC.
module pc_hang_detector #(
    parameter int HANG_CYCLES = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc,
    input  logic        stall,
    input  logic        enable,
    output logic        hang
);

    localparam int HW = (HANG_CYCLES > 1) ? $clog2(HANG_CYCLES) : 1;
    localparam logic [HW-1:0] HANG_LAST = HW'(HANG_CYCLES - 1);

    logic [31:0]   prev_pc;
    logic          prev_valid;
    logic [HW-1:0] hang_cnt;
    logic          same_pc;

    // prev_valid keeps a PC of 0 right after reset from counting as a repeat
    assign same_pc = prev_valid && (pc == prev_pc);
    assign hang    = enable && !stall && same_pc && (hang_cnt == HANG_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_pc    <= '0;
            prev_valid <= 1'b0;
            hang_cnt   <= '0;
        end else if (enable) begin
            prev_pc    <= pc;
            prev_valid <= 1'b1;
            if (!stall) begin
                if (!same_pc)
                    hang_cnt <= '0;
                else if (hang_cnt != HANG_LAST)
                    hang_cnt <= hang_cnt + HW'(1);
            end
        end
    end

endmodule

// File: rtl/riscv_test_monitor.sv
// End-of-test monitor: watches decode PC/inst and x3 to report pass/fail/timeout.
// State | meaning
// RUN   | program executing; watching for ecall, self-loop hang or timeout
// DRAIN | halt seen; waiting for in-flight writebacks to gp before sampling
// DONE  | result latched and held until reset
module riscv_test_monitor
    import riscv_test_monitor_pkg::*;
#(
    parameter int          TIMEOUT      = 1000,
    parameter int          DRAIN_CYCLES = 4,
    parameter int          HANG_CYCLES  = 8,
    parameter logic [31:0] ECALL_INST   = ECALL_INST_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc,
    input  logic [31:0] inst,
    input  logic        stall,
    input  logic [31:0] gp,
    output logic        done,
    output logic        pass,
    output logic        fail,
    output logic        timeout,
    output logic [30:0] test_num,
    output logic [31:0] cycles
);

    localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DW-1:0] DRAIN_LOAD   = DW'(DRAIN_CYCLES - 1);
    localparam logic [31:0]   TIMEOUT_LAST = 32'(TIMEOUT - 1);

    mon_state_e    state_q, state_d;
    logic [DW-1:0] drain_q, drain_d;
    logic [31:0]   cycles_d, cycles_inc;
    logic          done_d, pass_d, fail_d, timeout_d;
    logic [30:0]   test_num_d;
    logic          ecall_hit, hang;

    pc_hang_detector #(.HANG_CYCLES(HANG_CYCLES)) u_hang (
        .clk    (clk),
        .reset  (reset),
        .pc     (pc),
        .stall  (stall),
        .enable (state_q == MON_RUN),
        .hang   (hang)
    );

    assign ecall_hit  = !stall && (inst == ECALL_INST);
    assign cycles_inc = (cycles == 32'hFFFF_FFFF) ? cycles : cycles + 32'd1;

    always_comb begin
        state_d    = state_q;
        drain_d    = drain_q;
        cycles_d   = cycles;
        done_d     = done;
        pass_d     = pass;
        fail_d     = fail;
        timeout_d  = timeout;
        test_num_d = test_num;
        case (state_q)
            MON_RUN: begin
                cycles_d = cycles_inc;
                // a halt on the last RUN cycle still wins over the timeout
                if (ecall_hit || hang) begin
                    state_d = MON_DRAIN;
                    drain_d = DRAIN_LOAD;
                end else if (cycles == TIMEOUT_LAST) begin
                    state_d   = MON_DONE;
                    done_d    = 1'b1;
                    fail_d    = 1'b1;
                    timeout_d = 1'b1;
                end
            end
            MON_DRAIN: begin
                cycles_d = cycles_inc;
                if (drain_q == '0) begin
                    state_d = MON_DONE;
                    done_d  = 1'b1;
                    if (gp == 32'd1) begin
                        pass_d = 1'b1;
                    end else begin
                        fail_d     = 1'b1;
                        test_num_d = gp[0] ? gp[31:1] : 31'd0;
                    end
                end else begin
                    drain_d = drain_q - DW'(1);
                end
            end
            MON_DONE: ;
            default: state_d = MON_RUN;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= MON_RUN;
            drain_q  <= '0;
            cycles   <= '0;
            done     <= 1'b0;
            pass     <= 1'b0;
            fail     <= 1'b0;
            timeout  <= 1'b0;
            test_num <= '0;
        end else begin
            state_q  <= state_d;
            drain_q  <= drain_d;
            cycles   <= cycles_d;
            done     <= done_d;
            pass     <= pass_d;
            fail     <= fail_d;
            timeout  <= timeout_d;
            test_num <= test_num_d;
        end
    end

endmodule
